aud_i2s_master: RTL and testbench

AUD_I2S_MASTER -- requirements
Module: aud_i2s_master

---
 rtl/aud_pkg.sv | 18 +
 rtl/aud_i2s_master_if.sv | 15 +
 rtl/aud_bclk_gen.sv | 35 +++
 rtl/aud_i2s_master.sv | 114 +++++++++++
 tb/tb_aud_i2s_master.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aud_pkg.sv
// Shared framing constants and slot helpers for the I2S master.
// A frame is 64 bit clocks: two 32-bit slots, left then right.
package aud_pkg;

  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS  = 32;
  localparam int BIDX_W     = $clog2(FRAME_BITS);
  localparam int POS_W      = $clog2(SLOT_BITS);

  typedef logic [BIDX_W-1:0] bidx_t;
  typedef logic [POS_W-1:0]  pos_t;

  // Slot position 0 is the I2S one-bit delay; positions 1..data_w carry the sample MSB-first.
  function automatic logic pos_is_data(input pos_t p, input int data_w);
    return (p != '0) && (int'(p) <= data_w);
  endfunction

endpackage

// File: rtl/aud_i2s_master_if.sv
// Sample-pair stream into the I2S master: one pair per frame, accepted on the s_ready strobe.
// s_ready is a one-cycle strobe, not a level; the source simply keeps s_valid up while it has data.
interface aud_i2s_master_if #(
  parameter int DATA_W = 16
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_left;
  logic [DATA_W-1:0] s_right;

  modport master (output s_valid, output s_left, output s_right, input s_ready);
  modport slave  (input s_valid, input s_left, input s_right, output s_ready);

endinterface

// File: rtl/aud_bclk_gen.sv
// Bit-clock divider: AUD_BCLK toggles every BCLK_DIV clk cycles, first rise BCLK_DIV cycles after reset.
// Rise/fall strobes are high in the clk cycle whose closing edge makes AUD_BCLK go 0->1 / 1->0.
module aud_bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic AUD_BCLK,
  output logic bclk_rise,
  output logic bclk_fall
);

  localparam int CNT_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             half_done;

  assign half_done = (cnt == CNT_LAST);
  assign bclk_rise = half_done && !AUD_BCLK;
  assign bclk_fall = half_done && AUD_BCLK;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      AUD_BCLK <= 1'b0;
    end else if (half_done) begin
      cnt      <= '0;
      AUD_BCLK <= !AUD_BCLK;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/aud_i2s_master.sv
// I2S master transmitter: one sample pair per 64-bit frame, outputs change only on AUD_BCLK falls.
// Optional receive path under AUD_I2S_MASTER_RX_EN; m_* are registered on the s_ready strobe (visible next cycle).
module aud_i2s_master
  import aud_pkg::*;
#(
  parameter int BCLK_DIV = 4,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  aud_i2s_master_if.slave   s,
  output logic              AUD_BCLK,
  output logic              AUD_ADCLRCK,
  output logic              AUD_ADCDAT,
  output logic              underrun
`ifdef AUD_I2S_MASTER_RX_EN
  ,
  input  logic              AUD_DACDAT,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_left,
  output logic [DATA_W-1:0] m_right
`endif
);

  logic              bclk_rise;
  logic              bclk_fall;
  logic              frame_end;
  bidx_t             b;
  bidx_t             b_nxt;
  pos_t              p_nxt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] frame_r;
  logic [DATA_W-1:0] load_l;
  logic [DATA_W-1:0] load_r;

  aud_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk       (clk),
    .rst       (rst),
    .AUD_BCLK  (AUD_BCLK),
    .bclk_rise (bclk_rise),
    .bclk_fall (bclk_fall)
  );

  assign frame_end = bclk_fall && (b == bidx_t'(FRAME_BITS - 1));
  assign b_nxt     = b + bidx_t'(1);
  assign p_nxt     = b_nxt[POS_W-1:0];

  assign s.s_ready = frame_end;
  assign underrun  = frame_end && !s.s_valid;
  assign load_l    = s.s_valid ? s.s_left  : '0;
  assign load_r    = s.s_valid ? s.s_right : '0;

  // The left word goes straight into the shifter; the right word waits in frame_r until its slot opens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b           <= '1;
      AUD_ADCLRCK <= 1'b1;
      AUD_ADCDAT  <= 1'b0;
      tx_sh       <= '0;
      frame_r     <= '0;
    end else if (bclk_fall) begin
      b           <= b_nxt;
      AUD_ADCLRCK <= b_nxt[BIDX_W-1];
      if (frame_end) begin
        tx_sh      <= load_l;
        frame_r    <= load_r;
        AUD_ADCDAT <= 1'b0;
      end else if (b_nxt == bidx_t'(SLOT_BITS)) begin
        tx_sh      <= frame_r;
        AUD_ADCDAT <= 1'b0;
      end else if (pos_is_data(p_nxt, DATA_W)) begin
        AUD_ADCDAT <= tx_sh[DATA_W-1];
        tx_sh      <= tx_sh << 1;
      end else begin
        AUD_ADCDAT <= 1'b0;
      end
    end
  end

`ifdef AUD_I2S_MASTER_RX_EN
  logic [DATA_W-1:0] rx_l;
  logic [DATA_W-1:0] rx_r;

  // Data bits are captured on the rising bit-clock edge, mid-way through each bit cell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_l    <= '0;
      rx_r    <= '0;
      m_left  <= '0;
      m_right <= '0;
      m_valid <= 1'b0;
    end else begin
      m_valid <= frame_end;
      if (bclk_rise && pos_is_data(b[POS_W-1:0], DATA_W)) begin
        if (b[BIDX_W-1]) begin
          rx_r <= DATA_W'({rx_r, AUD_DACDAT});
        end else begin
          rx_l <= DATA_W'({rx_l, AUD_DACDAT});
        end
      end
      if (frame_end) begin
        m_left  <= rx_l;
        m_right <= rx_r;
      end
    end
  end
`else
  logic unused_bclk_rise;
  assign unused_bclk_rise = bclk_rise;
`endif

endmodule

// File: tb/tb_aud_i2s_master.sv
// Directed + random frames checked every cycle against a time-based model of the I2S frame.
module tb_aud_i2s_master;

  localparam int D         = 4;
  localparam int W         = 16;
  localparam int FRAME_CLK = 128 * D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic AUD_BCLK;
  logic AUD_ADCLRCK;
  logic AUD_ADCDAT;
  logic underrun;

  aud_i2s_master_if #(.DATA_W(W)) sif ();

`ifdef AUD_I2S_MASTER_RX_EN
  logic         AUD_DACDAT;
  logic         m_valid;
  logic [W-1:0] m_left;
  logic [W-1:0] m_right;
  assign AUD_DACDAT = AUD_ADCDAT;
`endif

  aud_i2s_master #(
    .BCLK_DIV (D),
    .DATA_W   (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s           (sif),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_ADCLRCK (AUD_ADCLRCK),
    .AUD_ADCDAT  (AUD_ADCDAT),
    .underrun    (underrun)
`ifdef AUD_I2S_MASTER_RX_EN
    ,
    .AUD_DACDAT  (AUD_DACDAT),
    .m_valid     (m_valid),
    .m_left      (m_left),
    .m_right     (m_right)
`endif
  );

  always #5 clk = ~clk;

  int           errors = 0;
  int           checks = 0;
  int           t = 0;
  int           mode = 1;
  logic [W-1:0] hold_l = '0, hold_r = '0;
  logic [W-1:0] cur_l = '0, cur_r = '0;
  logic [W-1:0] rx_exp_l = '0, rx_exp_r = '0;
  logic [W-1:0] exp_l = '0, exp_r = '0;
  logic         prev_sready = 1'b0;
  logic [63:0]  cap = '0, cap_lr = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Serial bit for frame bit-index b: slot delay bit, MSB-first sample, then zero padding.
  function automatic logic exp_bit(input int b, input logic [W-1:0] l, input logic [W-1:0] r);
    int p;
    logic [W-1:0] w;
    p = b % 32;
    w = (b < 32) ? l : r;
    if (p >= 1 && p <= W) return w[W-p];
    return 1'b0;
  endfunction

  // Bit index after tt clk edges since reset release: starts at 63, advances every 2*D edges.
  function automatic int b_of(input int tt);
    return (63 + tt / (2 * D)) % 64;
  endfunction

  task automatic drive();
    case (mode)
      0: begin
        sif.s_valid = 1'b1;
        sif.s_left  = hold_l;
        sif.s_right = hold_r;
      end
      1: begin
        sif.s_valid = 1'b0;
        sif.s_left  = W'($urandom);
        sif.s_right = W'($urandom);
      end
      default: begin
        sif.s_valid = ($urandom_range(0, 3) != 0);
        sif.s_left  = W'($urandom);
        sif.s_right = W'($urandom);
      end
    endcase
  endtask

  task automatic tick();
    logic exp_sready;
    int   b;
    @(negedge clk);
    drive();
    #1;
    t++;
    b          = b_of(t);
    exp_sready = ((t % FRAME_CLK) == 2 * D - 1);
    chk("bclk", AUD_BCLK, 64'((t / D) % 2));
    chk("s_ready", sif.s_ready, exp_sready);
    chk("underrun", underrun, exp_sready && !sif.s_valid);
    chk("lrck", AUD_ADCLRCK, b >= 32);
    chk("adcdat", AUD_ADCDAT, exp_bit(b, cur_l, cur_r));
    if ((t % (2 * D)) == D) begin
      cap    = {cap[62:0], AUD_ADCDAT};
      cap_lr = {cap_lr[62:0], AUD_ADCLRCK};
    end
`ifdef AUD_I2S_MASTER_RX_EN
    chk("m_valid", m_valid, prev_sready);
    if (prev_sready) begin
      chk("m_left", m_left, rx_exp_l);
      chk("m_right", m_right, rx_exp_r);
    end
`endif
    if (exp_sready) begin
      rx_exp_l = cur_l;
      rx_exp_r = cur_r;
      cur_l    = sif.s_valid ? sif.s_left  : '0;
      cur_r    = sif.s_valid ? sif.s_right : '0;
    end
    prev_sready = exp_sready;
  endtask

  task automatic run_to_sready();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (sif.s_ready !== 1'b1 && n < FRAME_CLK + 2);
    chk("sready_seen", sif.s_ready, 1'b1);
    chk("sready_phase", 64'(t % FRAME_CLK), 64'(2 * D - 1));
  endtask

  task automatic chk_reset_vals();
    chk("rst_bclk", AUD_BCLK, 1'b0);
    chk("rst_lrck", AUD_ADCLRCK, 1'b1);
    chk("rst_adcdat", AUD_ADCDAT, 1'b0);
    chk("rst_s_ready", sif.s_ready, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
`ifdef AUD_I2S_MASTER_RX_EN
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_left", m_left, '0);
    chk("rst_m_right", m_right, '0);
`endif
  endtask

  task automatic model_reset();
    t           = 0;
    cur_l       = '0;
    cur_r       = '0;
    rx_exp_l    = '0;
    rx_exp_r    = '0;
    prev_sready = 1'b0;
    cap         = '0;
    cap_lr      = '0;
  endtask

  initial begin
    int n;
    sif.s_valid = 1'b0;
    sif.s_left  = '0;
    sif.s_right = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Directed frame: fixed pattern, s_valid held.
    mode   = 0;
    hold_l = 16'hA5C3;
    hold_r = 16'h8001;
    run_to_sready();
    chk("first_sready_cycle", 64'(t), 64'(2 * D - 1));
    run_to_sready();
    chk("second_sready_cycle", 64'(t), 64'(2 * D - 1 + FRAME_CLK));
    chk("frameA_dat", cap, {1'b0, 16'hA5C3, 15'h0, 1'b0, 16'h8001, 15'h0});
    chk("frameA_lrck", cap_lr, 64'h0000_0000_FFFF_FFFF);

    // Underrun frame, then a normal one.
    mode = 1;
    run_to_sready();
    chk("underrun_pulse", underrun, 1'b1);
    mode   = 0;
    hold_l = W'($urandom);
    hold_r = W'($urandom);
    exp_l  = hold_l;
    exp_r  = hold_r;
    run_to_sready();
    chk("underrun_frame_zero", cap, 64'h0);
    mode = 2;
    run_to_sready();
    chk("after_underrun_dat", cap, {1'b0, exp_l, 15'h0, 1'b0, exp_r, 15'h0});

    repeat (6) run_to_sready();

    // Reset in the middle of a frame, at bit index 20 with AUD_BCLK high.
    mode   = 0;
    hold_l = W'($urandom);
    hold_r = W'($urandom);
    run_to_sready();
    n = 0;
    while (!(b_of(t) == 20 && AUD_BCLK === 1'b1) && n < FRAME_CLK) begin
      tick();
      n++;
    end
    chk("midframe_bclk_high", AUD_BCLK, 1'b1);
    rst = 1'b1;
    #1;
    chk_reset_vals();
    @(negedge clk);
    #1;
    chk_reset_vals();
    rst = 1'b0;
    model_reset();
    mode = 2;
    run_to_sready();
    chk("restart_first_sready", 64'(t), 64'(2 * D - 1));
    repeat (2) run_to_sready();

    // Fixed pattern over three frames (loopback receive when enabled).
    mode   = 0;
    hold_l = 16'h1234;
    hold_r = 16'hFEDC;
    repeat (3) run_to_sready();
    tick();
`ifdef AUD_I2S_MASTER_RX_EN
    chk("rx_m_valid", m_valid, 1'b1);
    chk("rx_m_left", m_left, 16'h1234);
    chk("rx_m_right", m_right, 16'hFEDC);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
